pipe_mux_sel: RTL and testbench
===============================

// Module: pipe_mux_sel
// PURPOSE
// - Parametrised NUM_IN:1 select of WIDTH-bit operands, followed by DEPTH registered stages with valid/ready backpressure.
// - Replaces the fixed 2:1 5-bit select used for register-destination choice: rt / rd / $31 / zero.
// - Also usable for wider datapath selects where the select result must be pipelined and stalled.
// - Sits between the decode-side operand sources and the next pipeline register; carries a flush path for branch squash.
// PARAMETERS
// - WIDTH    5     bits per operand and output
// - NUM_IN   4     number of selectable inputs (>=2)
// - SEL_W    2     select width; must satisfy 2**SEL_W >= NUM_IN
// - DEPTH    2     number of register stages (>=1); latency in cycles
// - DEFVAL   0     value emitted when Sel >= NUM_IN
// PORTS
// - Clk       in   1               rising-edge clock
// - Reset     in   1               synchronous, active-high reset
// - In        in   NUM_IN*WIDTH    packed operands; operand i = In[i*WIDTH +: WIDTH]
// - Sel       in   SEL_W           operand index, sampled with InValid
// - InValid   in   1               upstream has an item
// - InReady   out  1               block accepts an item this cycle
// - Flush     in   1               drop all in-flight items
// - Out       out  WIDTH           selected operand, DEPTH stages later
// - OutValid  out  1               Out/SelErr hold a valid item
// - OutReady  in   1               downstream accepts Out this cycle
// - SelErr    out  1               item was selected with out-of-range Sel
// - Count     out  $clog2(DEPTH+1) items currently held (0..DEPTH)
// BEHAVIOUR
// - Reset is synchronous and active-high: clock Clk, reset Reset.
// - After Reset: every stage valid=0, data=0, err=0, so Out=0, OutValid=0, SelErr=0, Count=0.
// - InReady=1 in the first cycle after Reset.
// - Selection is combinational at the input:
//   - Sel<NUM_IN: d = In[Sel*WIDTH +: WIDTH], e=0.
//   - Otherwise: d = DEFVAL, e=1.
// - Stage k register: {v_k, d_k, e_k}. Stage DEPTH-1 drives Out, OutValid, SelErr.
// - Ready chain:
//   - rdy_{DEPTH-1} = !v_{DEPTH-1} | OutReady.
//   - rdy_k = !v_k | rdy_{k+1}.
//   - InReady = rdy_0. Bubbles collapse; full throughput of 1 item/cycle.
// - Transfer in: InValid & InReady loads stage 0.
// - Stage k advances into k+1 when v_k & rdy_{k+1}.
// - A stage that loads nothing while its content leaves clears v_k.
// - Stall: if OutValid & !OutReady, Out and SelErr hold stable and all full stages hold.
// - InReady drops only once every stage is full.
// - Latency is exactly DEPTH cycles from accept to OutValid when no stall occurs.
// - Count:
//   - +1 on an input transfer; -1 on an output transfer (OutValid & OutReady).
//   - Unchanged when both or neither occur.
//   - Saturates by construction: 0..DEPTH.
// - Flush=1 at a clock edge:
//   - All v_k cleared and Count set to 0.
//   - Any input transfer in that cycle is discarded; Flush wins.
//   - Data/err registers keep stale values. They are don't-care while OutValid=0.
// - Reset mid-stream: same effect as Flush, plus data/err cleared to 0. Reset outranks Flush.
// - Sel/In changes while InReady=0 have no effect; the item is captured only on transfer.
// - No combinational path from In/Sel/InValid to Out/OutValid.
// - OutReady reaches InReady combinationally through the ready chain.
// STRUCTURE
// - Shared pipeline package: localparams for the MIPS destination select.
//   - REGDST_RT=0, REGDST_RD=1, REGDST_RA=2, REG_RA_ADDR=5'd31.
// - One sub-module: pipe_stage_reg (WIDTH+1 data bits, valid/ready, flush, reset), instantiated DEPTH times in a generate loop.
// - The select and Count logic live in the top module.
// TESTING
// - Reset: assert Reset 2 cycles with InValid=1 -> OutValid=0, Out=0, Count=0; InReady=1 the cycle after release.
// - Stream: WIDTH=5, NUM_IN=4, In={5'd31,5'd0,5'd12,5'd7}, Sel=0,1,2,3 on consecutive cycles, OutReady=1
//   -> Out=7,12,0,31 starting exactly 2 cycles after the first accept, SelErr=0.
// - Range error: NUM_IN=3, SEL_W=2, Sel=3, DEFVAL=5'd0 -> Out=0, SelErr=1; the next item with Sel=1 has SelErr=0.
// - Backpressure: OutReady=0 for 4 cycles with continuous input
//   -> InReady falls after 2 accepts, Count=2, Out stable.
//   -> OutReady=1 resumes with no loss or duplication; order preserved.
// - Flush: Count=2 with Flush=1 and InValid=1 in the same cycle -> next cycle Count=0, OutValid=0, and the flushed-cycle item never appears.
// - Simultaneous in/out: Count=1, input transfer and output transfer in the same cycle -> Count stays 1, new item emerges next.

Source files
------------

// File: rtl/pipe_mux_sel_pkg.sv
// Shared pipeline definitions: register-destination select codes and small
// helpers used by the operand select pipeline.
package pipe_mux_sel_pkg;

  localparam logic [1:0] REGDST_RT   = 2'd0;
  localparam logic [1:0] REGDST_RD   = 2'd1;
  localparam logic [1:0] REGDST_RA   = 2'd2;
  localparam logic [1:0] REGDST_ZERO = 2'd3;

  localparam logic [4:0] REG_RA_ADDR   = 5'd31;
  localparam logic [4:0] REG_ZERO_ADDR = 5'd0;

  function automatic logic sel_in_range(input int unsigned sel, input int unsigned num_in);
    return (sel < num_in);
  endfunction

endpackage

// File: rtl/pipe_mux_sel_stage.sv
// One valid/ready pipeline register slot. Loads whenever it is empty or its
// current content is leaving; flush drops the valid bit but keeps the payload.
module pipe_stage_reg
  import pipe_mux_sel_pkg::*;
#(
  parameter int unsigned DW = 6
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          flush_i,
  input  logic          up_valid_i,
  input  logic [DW-1:0] up_data_i,
  input  logic          down_ready_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q;
  logic          valid_d;
  logic [DW-1:0] data_q;
  logic [DW-1:0] data_d;
  logic          load_en_s;

  // Next-state for the slot: flush first, otherwise refill when there is room.
  always_comb begin
    load_en_s = ~valid_q | down_ready_i;
    valid_d   = valid_q;
    data_d    = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_en_s) begin
      valid_d = up_valid_i;
      if (up_valid_i) begin
        data_d = up_data_i;
      end else begin
        data_d = data_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot state register with synchronous reset clearing payload as well.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      data_q  <= {DW{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_mux_sel.sv
// NUM_IN:1 operand select followed by DEPTH valid/ready register stages with
// flush, an out-of-range flag and an occupancy count.
module pipe_mux_sel
  import pipe_mux_sel_pkg::*;
#(
  parameter int unsigned      WIDTH  = 5,
  parameter int unsigned      NUM_IN = 4,
  parameter int unsigned      SEL_W  = 2,
  parameter int unsigned      DEPTH  = 2,
  parameter logic [WIDTH-1:0] DEFVAL = {WIDTH{1'b0}}
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [NUM_IN*WIDTH-1:0]    In,
  input  logic [SEL_W-1:0]           Sel,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic                       Flush,
  output logic [WIDTH-1:0]           Out,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic                       SelErr,
  output logic [$clog2(DEPTH+1)-1:0] Count
);

  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned NSLOT  = 2 ** SEL_W;

  logic [WIDTH-1:0] opnd_s [NSLOT];
  logic [WIDTH-1:0] sel_data_s;
  logic             sel_err_s;
  logic [DEPTH-1:0] stage_v_s;
  logic [WIDTH:0]   stage_d_s [DEPTH];
  logic [DEPTH:0]   rdy_s;
  logic             in_xfer_s;
  logic             out_xfer_s;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Unused select codes read DEFVAL so the mux is always fully populated.
  for (genvar i = 0; i < NSLOT; i++) begin : g_opnd
    if (i < NUM_IN) begin : g_live
      assign opnd_s[i] = In[i*WIDTH +: WIDTH];
    end else begin : g_dead
      assign opnd_s[i] = DEFVAL;
    end
  end

  // Input select and range flag.
  always_comb begin
    sel_data_s = DEFVAL;
    sel_err_s  = 1'b1;
    if (sel_in_range(32'(Sel), NUM_IN)) begin
      sel_data_s = opnd_s[Sel];
      sel_err_s  = 1'b0;
    end else begin
      sel_data_s = DEFVAL;
      sel_err_s  = 1'b1;
    end
  end

  // A stage can accept when it, or any stage downstream of it, has a hole.
  assign rdy_s[DEPTH] = OutReady;
  for (genvar k = 0; k < DEPTH; k++) begin : g_rdy
    assign rdy_s[k] = OutReady | ~(&stage_v_s[DEPTH-1:k]);
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic           up_valid_s;
    logic [WIDTH:0] up_data_s;

    if (k == 0) begin : g_head
      assign up_valid_s = InValid;
      assign up_data_s  = {sel_err_s, sel_data_s};
    end else begin : g_body
      assign up_valid_s = stage_v_s[k-1];
      assign up_data_s  = stage_d_s[k-1];
    end

    pipe_stage_reg #(
      .DW (WIDTH + 1)
    ) u_stage (
      .clk_i        (Clk),
      .reset_i      (Reset),
      .flush_i      (Flush),
      .up_valid_i   (up_valid_s),
      .up_data_i    (up_data_s),
      .down_ready_i (rdy_s[k+1]),
      .valid_o      (stage_v_s[k]),
      .data_o       (stage_d_s[k])
    );
  end

  // Occupancy tracking from the two transfer strobes.
  always_comb begin
    in_xfer_s  = InValid & rdy_s[0];
    out_xfer_s = stage_v_s[DEPTH-1] & OutReady;
    count_d    = count_q;
    if (Flush) begin
      count_d = {CNT_W{1'b0}};
    end else begin
      case ({in_xfer_s, out_xfer_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Occupancy register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign InReady  = rdy_s[0];
  assign OutValid = stage_v_s[DEPTH-1];
  assign Out      = stage_d_s[DEPTH-1][WIDTH-1:0];
  assign SelErr   = stage_d_s[DEPTH-1][WIDTH];
  assign Count    = count_q;

endmodule

// File: tb/tb_pipe_mux_sel.sv
// Directed bench for pipe_mux_sel: table-driven stream/backpressure/flush
// vectors plus hand sequences for reset, range error and concurrent transfers.
module tb_pipe_mux_sel;
  import pipe_mux_sel_pkg::*;

  typedef struct {
    logic       fl;
    logic       iv;
    logic [1:0] sel;
    logic       ordy;
    logic       ev;
    logic [4:0] eout;
    logic [1:0] ecnt;
    logic       erdy;
  } vec_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Flush = 1'b0;

  logic [19:0] In = {REG_RA_ADDR, 5'd0, 5'd12, 5'd7};
  logic [1:0]  Sel = 2'd0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [4:0]  Out;
  logic        OutValid;
  logic        OutReady = 1'b0;
  logic        SelErr;
  logic [1:0]  Count;

  logic [14:0] e_In = {5'd9, 5'd12, 5'd7};
  logic [1:0]  e_Sel = 2'd0;
  logic        e_InValid = 1'b0;
  logic        e_InReady;
  logic [4:0]  e_Out;
  logic        e_OutValid;
  logic        e_OutReady = 1'b1;
  logic        e_SelErr;
  logic [1:0]  e_Count;

  int total = 0;
  int bad   = 0;
  vec_t vecs [21];

  always #5 Clk = ~Clk;

  pipe_mux_sel u_dut (
    .Clk(Clk), .Reset(Reset), .In(In), .Sel(Sel), .InValid(InValid),
    .InReady(InReady), .Flush(Flush), .Out(Out), .OutValid(OutValid),
    .OutReady(OutReady), .SelErr(SelErr), .Count(Count)
  );

  pipe_mux_sel #(.NUM_IN(3)) u_err (
    .Clk(Clk), .Reset(Reset), .In(e_In), .Sel(e_Sel), .InValid(e_InValid),
    .InReady(e_InReady), .Flush(Flush), .Out(e_Out), .OutValid(e_OutValid),
    .OutReady(e_OutReady), .SelErr(e_SelErr), .Count(e_Count)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    //             fl    iv    sel   ordy  ev    eout   ecnt  erdy
    vecs[0]  = '{1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 5'd0,  2'd1, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 5'd7,  2'd2, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 5'd12, 2'd2, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 5'd0,  2'd2, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 5'd31, 2'd1, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 5'd0,  2'd0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 5'd0,  2'd1, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 5'd7,  2'd2, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 5'd7,  2'd2, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 5'd7,  2'd2, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 5'd12, 2'd2, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 5'd0,  2'd2, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 5'd31, 2'd1, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 5'd0,  2'd0, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 5'd0,  2'd1, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 5'd7,  2'd2, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 5'd0,  2'd0, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 5'd0,  2'd0, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 5'd0,  2'd1, 1'b1};
    vecs[19] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 5'd12, 2'd1, 1'b1};
    vecs[20] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 5'd0,  2'd0, 1'b1};

    // Reset held two cycles with an item offered.
    Reset = 1'b1; InValid = 1'b1; OutReady = 1'b1; Sel = 2'd1;
    for (int r = 0; r < 2; r++) begin
      tick();
      chk("rst_valid", 32'(OutValid), 32'd0);
      chk("rst_out",   32'(Out),      32'd0);
      chk("rst_err",   32'(SelErr),   32'd0);
      chk("rst_count", 32'(Count),    32'd0);
    end
    Reset = 1'b0; InValid = 1'b0;
    tick();
    chk("rel_inready", 32'(InReady),  32'd1);
    chk("rel_valid",   32'(OutValid), 32'd0);
    chk("rel_count",   32'(Count),    32'd0);

    // Stream, backpressure and flush vectors.
    for (int v = 0; v < 21; v++) begin
      Flush = vecs[v].fl; InValid = vecs[v].iv; Sel = vecs[v].sel; OutReady = vecs[v].ordy;
      tick();
      chk($sformatf("v%0d_valid", v),   32'(OutValid), 32'(vecs[v].ev));
      chk($sformatf("v%0d_count", v),   32'(Count),    32'(vecs[v].ecnt));
      chk($sformatf("v%0d_inready", v), 32'(InReady),  32'(vecs[v].erdy));
      if (vecs[v].ev) begin
        chk($sformatf("v%0d_out", v), 32'(Out),    32'(vecs[v].eout));
        chk($sformatf("v%0d_err", v), 32'(SelErr), 32'd0);
      end
    end
    Flush = 1'b0;

    // Concurrent accept and drain at Count=1.
    InValid = 1'b1; Sel = 2'd0; OutReady = 1'b1;
    tick();
    InValid = 1'b0;
    tick();
    chk("sim_pre_out",   32'(Out),   32'd7);
    chk("sim_pre_count", 32'(Count), 32'd1);
    InValid = 1'b1; Sel = 2'd3;
    tick();
    chk("sim_count",  32'(Count),    32'd1);
    chk("sim_valid0", 32'(OutValid), 32'd0);
    InValid = 1'b0;
    tick();
    chk("sim_new_valid", 32'(OutValid), 32'd1);
    chk("sim_new_out",   32'(Out),      32'd31);
    chk("sim_new_count", 32'(Count),    32'd1);
    tick();
    chk("sim_drain_count", 32'(Count), 32'd0);

    // Reset while full, with Flush also high, clears data too.
    InValid = 1'b1; Sel = 2'd3; OutReady = 1'b0;
    tick();
    tick();
    chk("mid_full_out",   32'(Out),   32'd31);
    chk("mid_full_count", 32'(Count), 32'd2);
    Reset = 1'b1; Flush = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(OutValid), 32'd0);
    chk("mid_rst_out",   32'(Out),      32'd0);
    chk("mid_rst_count", 32'(Count),    32'd0);
    Reset = 1'b0; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    tick();
    chk("mid_rel_valid",   32'(OutValid), 32'd0);
    chk("mid_rel_inready", 32'(InReady),  32'd1);

    // Out-of-range select on the 3-input instance.
    e_InValid = 1'b1; e_Sel = 2'd3;
    tick();
    e_Sel = 2'd1;
    tick();
    chk("rng_valid", 32'(e_OutValid), 32'd1);
    chk("rng_out",   32'(e_Out),      32'd0);
    chk("rng_err",   32'(e_SelErr),   32'd1);
    e_InValid = 1'b0;
    tick();
    chk("rng_next_valid", 32'(e_OutValid), 32'd1);
    chk("rng_next_out",   32'(e_Out),      32'd12);
    chk("rng_next_err",   32'(e_SelErr),   32'd0);
    tick();
    chk("rng_empty_count", 32'(e_Count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
